// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, per-buffer stall/flush commands out.
// The controller side takes the slave modport; the pipeline/bench side takes master.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_halt;
  logic             ex_redirect;
  logic             mem_busy;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_stall;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_memread, ex_rd, ex_halt, ex_redirect, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_stall, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_memread, ex_rd, ex_halt, ex_redirect, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_stall, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: load-use stall, EX redirect flush, busy-memory freeze, Halt drain.
// Optional saturating stall/flush performance counters under `HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic          halted_q;

  logic load_use;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_stall;

  assign load_use = hz.ex_memread && (hz.ex_rd != '0) &&
                    ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (hz.mem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
          end else if (hz.ex_halt || (!hz.ex_redirect && load_use)) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        DRAIN: begin
          // Fetch stays blocked; a busy memory additionally freezes the retiring stages.
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (hz.mem_busy) begin
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
          end
        end
        HALTED: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      dcnt     <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!hz.mem_busy && hz.ex_halt) begin
            state <= DRAIN;
            dcnt  <= DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (!hz.mem_busy) begin
            if (dcnt == '0) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else begin
              dcnt <= dcnt - 1'b1;
            end
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_stall = ex_mem_stall;
  assign hz.mem_wb_stall = mem_wb_stall;
  assign hz.halted       = halted_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((if_id_flush || id_ex_flush) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences followed by random traffic,
// checked against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int CW    = 4;
  localparam int DRAIN = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall}
  typedef struct {
    logic [6:0]    ctrl;
    logic          halted;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: pipeline mode plus "non-frozen cycles still to retire" before halt.
  bit m_draining = 0;
  bit m_halted   = 0;
  int m_left     = 0;
  int m_sc       = 0;
  int m_fc       = 0;

  task automatic cyc(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit mr, input logic [4:0] rd, input bit h, input bit rdr,
                     input bit busy);
    exp_t e;
    bit   ps, is, iflush, ids, idflush, ems, mws, lu;
    @(posedge clk);
    #1;
    reset          = r;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.ex_memread  = mr;
    hz.ex_rd       = rd;
    hz.ex_halt     = h;
    hz.ex_redirect = rdr;
    hz.mem_busy    = busy;

    {ps, is, iflush, ids, idflush, ems, mws} = '0;
    lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    if (!r) begin
      if (m_halted || m_draining) begin
        {ps, is, idflush} = 3'b111;
        if (m_draining && busy) {ids, ems, mws} = 3'b111;
      end else if (busy) begin
        {ps, is, ids, ems, mws} = 5'b11111;
      end else if (h) begin
        {ps, is, idflush} = 3'b111;
      end else if (rdr) begin
        {iflush, idflush} = 2'b11;
      end else if (lu) begin
        {ps, is, idflush} = 3'b111;
      end
    end
    e.ctrl   = {ps, is, iflush, ids, idflush, ems, mws};
    e.halted = m_halted;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    q.push_back(e);

    if (r) begin
      m_draining = 0; m_halted = 0; m_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (ps && m_sc < CMAX) m_sc++;
      if ((iflush || idflush) && m_fc < CMAX) m_fc++;
      if (m_draining) begin
        if (!busy) begin
          m_left--;
          if (m_left == 0) begin
            m_draining = 0;
            m_halted   = 1;
          end
        end
      end else if (!m_halted && !busy && h) begin
        m_draining = 1;
        m_left     = DRAIN;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  // Monitor: outputs are combinational/registered and settled by the falling edge.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
               hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_stall};
        n_tests++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
        end
        n_tests++;
        if (hz.halted !== e.halted) begin
          n_fail++;
          $display("FAIL halted t=%0t got=%b want=%b", $time, hz.halted, e.halted);
        end
        n_tests++;
        if (hz.stall_cnt !== e.sc || hz.flush_cnt !== e.fc) begin
          n_fail++;
          $display("FAIL perf_cnt t=%0t got=%0d/%0d want=%0d/%0d", $time,
                   hz.stall_cnt, hz.flush_cnt, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.ex_memread = 0; hz.ex_rd = '0;
    hz.ex_halt = 0; hz.ex_redirect = 0; hz.mem_busy = 0;

    do_reset();
    idle(2);
    // load-use on rs2, then ex_rd=0 must not stall
    cyc(0, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0);
    idle(1);
    cyc(0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    // redirect wins over a simultaneous load-use
    cyc(0, 5'd7, 5'd1, 1, 5'd7, 0, 1, 0);
    idle(1);
    // busy memory freezes a pending redirect for 3 cycles, flush follows
    repeat (3) cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
    cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
    idle(2);
    // plain halt drain, then sit halted
    cyc(0, 5'd1, 5'd2, 0, 5'd0, 1, 1, 0);
    idle(5);
    do_reset();
    // halt drain stretched by one busy cycle, reset afterwards
    cyc(0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0);
    cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1);
    idle(4);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    idle(2);
    // reset in the middle of a drain
    cyc(0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    idle(4);
    // counters: two load-use events and one redirect
    do_reset();
    cyc(0, 5'd4, 5'd9, 1, 5'd4, 0, 0, 0);
    idle(1);
    cyc(0, 5'd9, 5'd4, 1, 5'd4, 0, 0, 0);
    cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0));
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Backward-direction control for the 5-stage pipeline. The IF/ID, ID/EX, EX/MEM and MEM/WB buffers carry data and control forward; this block returns stall, flush and freeze commands to those buffers and to the PC.
- It detects load-use hazards and taken branches/jumps in EX, and it freezes the whole pipe on a busy data memory.
- It also sequences the Halt drain: it stops fetch, lets the instructions already in EX/MEM/WB retire, then reports halted.

Parameters:
- DRAIN_CYCLES, 2, number of non-frozen cycles after Halt leaves EX before halted asserts (EX->MEM->WB).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 field of the instruction in IF/ID
- id_rs2  in  5  rs2 field of the instruction in IF/ID
- ex_memread  in  1  MemRead bit from ID/EX
- ex_rd  in  5  rd from ID/EX
- ex_halt  in  1  Halt bit from ID/EX
- ex_redirect  in  1  taken branch, Jump or JumpReg resolved in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  zero ID/EX (bubble) on next edge
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_stall  out  1  hold MEM/WB
- halted  out  1  pipeline fully drained after Halt
- stall_cnt  out  CNT_W  cycles with pc_stall=1 (optional feature)
- flush_cnt  out  CNT_W  cycles with if_id_flush or id_ex_flush=1 (optional feature)

Behaviour:
- FSM states: RUN, DRAIN, HALTED. State and drain counter dcnt are updated on the clk rising edge.
- Reset:
  - State goes to RUN and dcnt to 0; halted and both counters go to 0.
  - While reset is high, all stall and flush outputs are forced to 0.
- Stall/flush outputs are combinational from state and inputs, so they take effect in the same cycle.
- RUN, evaluated in priority order (first match wins):
  1. mem_busy=1: all five *_stall=1, both flushes 0. No state change.
  2. ex_halt=1: pc_stall=1, if_id_stall=1, id_ex_flush=1. Next state DRAIN with dcnt=DRAIN_CYCLES-1. ex_redirect is ignored in this cycle.
  3. ex_redirect=1: if_id_flush=1, id_ex_flush=1, pc_stall=0 so the PC loads the target. A load-use hazard in the same cycle is ignored.
  4. Load-use: ex_memread=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2. Response is pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle; the load then moves to MEM and the condition clears.
  5. Otherwise all outputs are 0.
- DRAIN:
  - pc_stall=1, if_id_stall=1, id_ex_flush=1 are held.
  - If mem_busy=1, all *_stall=1 and dcnt holds.
  - Otherwise: if dcnt=0, next state is HALTED; else dcnt decrements.
- HALTED:
  - halted=1 (registered, asserted on entry).
  - pc_stall=1, if_id_stall=1, id_ex_flush=1 are held.
  - Exit only by reset.
- Latency: with no busy cycles, Halt in EX at cycle N gives halted=1 at cycle N+1+DRAIN_CYCLES (N+3 by default).
- ex_rd=0 never causes a stall.
- Reset asserted during DRAIN returns the FSM to RUN with dcnt=0 on the same edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each non-reset cycle with pc_stall=1.
  - flush_cnt increments on each non-reset cycle with if_id_flush|id_ex_flush=1.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Not defined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for one cycle -> pc_stall=1, if_id_stall=1, id_ex_flush=1 that cycle, all 0 the next cycle. Repeat with ex_rd=0 -> no stall.
- Redirect: ex_redirect=1 with a simultaneous load-use match -> if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0.
- Memory busy: mem_busy=1 for 3 cycles during ex_redirect=1 -> all five stalls=1, flushes=0 for 3 cycles. Flush occurs in the first cycle after mem_busy drops.
- Halt: ex_halt=1 at cycle 10 -> halted=0 through cycle 12, halted=1 at cycle 13. pc_stall stays 1 from cycle 10 onward.
- Halt drain with mem_busy=1 at cycle 11 -> halted at cycle 14. Reset at cycle 15 -> halted=0 and all outputs 0 at cycle 16.
- HAZARD_PERF_CNT_EN defined: two load-use events and one redirect -> stall_cnt=2, flush_cnt=3. Undefined -> both read 0.
